// File: rtl/multiply_4x4_pkg.sv
// Shared constants for the unsigned array multiplier.
// WIDTH alone sizes every port, so no typedefs live here.
package multiply_4x4_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;
    localparam int STAGES    = 2;

    // Full-precision product width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/multiply_4x4_if.sv
// Operand/product bus of the multiplier.
// The master side issues operand pairs; the slave side returns products.
interface multiply_4x4_if #(
    parameter int WIDTH = multiply_4x4_pkg::DEF_WIDTH
) ();
    import multiply_4x4_pkg::*;

    logic                         in_valid;
    logic [WIDTH-1:0]             A;
    logic [WIDTH-1:0]             B;
    logic                         out_valid;
    logic [prod_width(WIDTH)-1:0] P;

    modport master (
        output in_valid, A, B,
        input  out_valid, P
    );

    modport slave (
        input  in_valid, A, B,
        output out_valid, P
    );
endinterface

// File: rtl/multiply_4x4_mul_row_add.sv
// One row of the partial-product array: adds (B[k] ? A<<k : 0) to the
// running sum handed down from the previous row.
module mul_row_add
    import multiply_4x4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = 1
) (
    input  logic [prod_width(WIDTH)-1:0] i_sum,
    input  logic [WIDTH-1:0]             i_a,
    input  logic                         i_b_bit,
    output logic [prod_width(WIDTH)-1:0] o_sum
);
    localparam int PW = prod_width(WIDTH);

    logic [PW-1:0] w_row;

    // Zero-extend before shifting so the top bits of A are never dropped.
    assign w_row = i_b_bit ? ({{WIDTH{1'b0}}, i_a} << SHIFT) : '0;
    assign o_sum = i_sum + w_row;
endmodule

// File: rtl/multiply_4x4.sv
// Unsigned WIDTH x WIDTH array multiplier: operands registered on edge N,
// full-precision product and its valid presented after edge N+1.
module multiply_4x4
    import multiply_4x4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    multiply_4x4_if.slave  bus
);
    localparam int PW = prod_width(WIDTH);

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [PW-1:0]     r_p;
    logic [STAGES-1:0] r_vld_pipe;
    logic [PW-1:0]     w_sum [WIDTH];

    // Stage 1: operands are captured every cycle; only the valid bit
    // distinguishes a real pair from idle traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= bus.A;
            r_b <= bus.B;
        end
    end

    // Row 0 needs no adder; each later row accumulates onto the previous sum.
    assign w_sum[0] = r_b[0] ? {{WIDTH{1'b0}}, r_a} : '0;

    genvar k;
    generate
        for (k = 1; k < WIDTH; k++) begin : g_row
            mul_row_add #(
                .WIDTH (WIDTH),
                .SHIFT (k)
            ) u_row (
                .i_sum   (w_sum[k-1]),
                .i_a     (r_a),
                .i_b_bit (r_b[k]),
                .o_sum   (w_sum[k])
            );
        end
    endgenerate

    // Stage 2 and the valid pipeline; reset drops every in-flight pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p        <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_p        <= w_sum[WIDTH-1];
            r_vld_pipe <= {r_vld_pipe[STAGES-2:0], bus.in_valid};
        end
    end

    assign bus.P         = r_p;
    assign bus.out_valid = r_vld_pipe[STAGES-1];
endmodule

// File: tb/tb_multiply_4x4.sv
// Scoreboard bench for multiply_4x4: issued pairs queue their product,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_multiply_4x4;
    localparam int W  = 4;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] p;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errs   = 0;
    int   cyc    = 0;
    logic rst_seen = 1'b0;
    exp_t sb[$];

    multiply_4x4_if #(.WIDTH(W)) bus ();

    multiply_4x4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: reset drops everything in flight; a valid pair
    // accepted on edge N is due after edge N+1 as plain A*B.
    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_seen = rst;
        if (rst) begin
            sb.delete();
        end else if (bus.in_valid) begin
            exp_t e;
            e.p   = PW'(int'(bus.A) * int'(bus.B));
            e.cyc = cyc;
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.P !== '0) begin
                errs++;
                $display("FAIL reset_state cyc=%0d out_valid=%b P=%0d want out_valid=0 P=0",
                         cyc, bus.out_valid, bus.P);
            end
        end else if (bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_valid cyc=%0d P=%0d want no output", cyc, bus.P);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.P !== e.p || cyc != e.cyc + 1) begin
                    errs++;
                    $display("FAIL product cyc=%0d P=%0d want P=%0d at cyc=%0d",
                             cyc, bus.P, e.p, e.cyc + 1);
                end
            end
        end else begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errs++;
                $display("FAIL valid_x cyc=%0d out_valid=%b want 0", cyc, bus.out_valid);
            end else if (sb.size() != 0 && sb[0].cyc + 1 <= cyc) begin
                errs++;
                $display("FAIL missing_valid cyc=%0d out_valid=0 want P=%0d", cyc, sb[0].p);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic v, input int a, input int b, input logic r);
        bus.in_valid = v;
        bus.A        = W'(a);
        bus.B        = W'(b);
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stream_a[5] = '{1, 2, 8, 9, 10};
        int stream_b[5] = '{2, 2, 8, 9, 10};
        int bnd_a[4]    = '{0, 15, 15, 1};
        int bnd_b[4]    = '{15, 0, 15, 13};

        bus.in_valid = 1'b1;
        bus.A        = 4'd9;
        bus.B        = 4'd9;
        // Reset held with a valid pair on the bus must produce nothing.
        step(1'b1, 9, 9, 1'b1);
        step(1'b1, 9, 9, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, stream_a[i], stream_b[i], 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, bnd_a[i], bnd_b[i], 1'b0);

        step(1'b1, 3, 5, 1'b0);
        step(1'b0, 1, 1, 1'b0);
        step(1'b0, 2, 2, 1'b0);
        step(1'b1, 7, 6, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        // Reset on the edge after (12,12) is captured kills its result.
        step(1'b1, 12, 12, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                step(1'b1, a, b, 1'b0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));

        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end
endmodule
